// File: rtl/keysw_io_responder.sv
// keysw_io_responder: KEY/SW bus responder with sync, debounce, sticky W1C event flags; optional irq/KIE under KEYSW_IRQ_EN
`timescale 1ns/1ps
module keysw_io_responder #(
  parameter int          DEBOUNCE_CYCLES = 100000,
  parameter logic [31:0] ADDR_KEY        = 32'hF0000010,
  parameter logic [31:0] ADDR_SW         = 32'hF0000014,
  parameter logic [31:0] ADDR_KSTAT      = 32'hF0000110,
  parameter logic [31:0] ADDR_SSTAT      = 32'hF0000114
`ifdef KEYSW_IRQ_EN
  , parameter logic [31:0] ADDR_KIE      = 32'hF0000120
`endif
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic        wrEn,
  input  logic [31:0] wrData,
  output logic [31:0] rdData,
  output logic        sel,
  input  logic [3:0]  KEY,
  input  logic [9:0]  SW
`ifdef KEYSW_IRQ_EN
  , output logic      irq
`endif
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES - 1);
  typedef enum logic {INIT, RUN} state_t;
  state_t state, state_next;
  logic [1:0] init_cnt;
  logic [3:0] k_s1, k_s2;
  logic [9:0] s_s1, s_s2;
  logic [13:0] lvl, deb, upd;
  logic [CW-1:0] cnt [14];
  logic [3:0] kflag, press;
  logic [9:0] sflag;
  logic kov, sov;
  logic [4:0] kclr;
  logic [10:0] sclr;
  logic [31:0] rd;
  logic unused_ok;
  // bit b: [3:0] keys (inverted, 1 = pressed), [13:4] switches
  assign lvl = {s_s2, ~k_s2};
  assign press = upd[3:0] & ~deb[3:0];
  assign kclr = (wrEn && addr == ADDR_KSTAT) ? wrData[4:0] : '0;
  assign sclr = (wrEn && addr == ADDR_SSTAT) ? wrData[10:0] : '0;
  assign unused_ok = ^wrData[31:11];
  // state register and INIT length counter
  always_ff @(posedge clk)
    if (reset) begin
      state <= INIT;
      init_cnt <= '0;
    end else begin
      state <= state_next;
      init_cnt <= (state == INIT) ? init_cnt + 2'd1 : init_cnt;
    end
  // INIT holds for four cycles, RUN is terminal
  always_comb state_next = (state == INIT && init_cnt == 2'd3) ? RUN : state;
  // a bit's debounced level flips on the edge its counter expires with the level still different
  always_comb begin
    upd = '0;
    for (int b = 0; b < 14; b++) upd[b] = state == RUN && lvl[b] != deb[b] && cnt[b] == CMAX;
  end
  // synchronisers, debounced levels and per-bit hold counters
  always_ff @(posedge clk)
    if (reset) begin
      k_s1 <= '0;
      k_s2 <= '0;
      s_s1 <= '0;
      s_s2 <= '0;
      deb <= '0;
      for (int b = 0; b < 14; b++) cnt[b] <= '0;
    end else begin
      k_s1 <= KEY;
      k_s2 <= k_s1;
      s_s1 <= SW;
      s_s2 <= s_s1;
      for (int b = 0; b < 14; b++) begin
        cnt[b] <= (state == INIT || lvl[b] == deb[b] || upd[b]) ? '0 : cnt[b] + CW'(1);
        if (state == INIT || upd[b]) deb[b] <= lvl[b];
      end
    end
  // sticky event flags; a new event beats a same-edge clear and then raises no overrun
  always_ff @(posedge clk)
    if (reset) begin
      kflag <= '0;
      kov <= 1'b0;
      sflag <= '0;
      sov <= 1'b0;
    end else begin
      kflag <= press | (kflag & ~kclr[3:0]);
      kov <= |(press & kflag & ~kclr[3:0]) | (kov & ~kclr[4]);
      sflag <= upd[13:4] | (sflag & ~sclr[9:0]);
      sov <= |(upd[13:4] & sflag & ~sclr[9:0]) | (sov & ~sclr[10]);
    end
`ifdef KEYSW_IRQ_EN
  logic [4:0] kie;
  // interrupt enable register and registered interrupt
  always_ff @(posedge clk)
    if (reset) begin
      kie <= '0;
      irq <= 1'b0;
    end else begin
      if (wrEn && addr == ADDR_KIE) kie <= wrData[4:0];
      irq <= |(kflag & kie[3:0]) | (kie[4] & |sflag);
    end
`endif
  // combinational address decode and read mux, forced to zero while in reset
  always_comb begin
    rd = addr == ADDR_KEY   ? {28'd0, deb[3:0]} :
         addr == ADDR_SW    ? {22'd0, deb[13:4]} :
         addr == ADDR_KSTAT ? {27'd0, kov, kflag} :
         addr == ADDR_SSTAT ? {21'd0, sov, sflag} :
`ifdef KEYSW_IRQ_EN
         addr == ADDR_KIE   ? {27'd0, kie} :
`endif
         32'd0;
    sel = addr == ADDR_KEY || addr == ADDR_SW || addr == ADDR_KSTAT || addr == ADDR_SSTAT
`ifdef KEYSW_IRQ_EN
          || addr == ADDR_KIE
`endif
          ;
    rdData = reset ? 32'd0 : rd;
  end
endmodule

// File: tb/tb_keysw_io_responder.sv
// tb_keysw_io_responder: scoreboard bench for keysw_io_responder (DEBOUNCE_CYCLES=4; irq checks under KEYSW_IRQ_EN)
`timescale 1ns/1ps
module tb_keysw_io_responder;
  localparam logic [31:0] A_KEY = 32'hF0000010;
  localparam logic [31:0] A_SW = 32'hF0000014;
  localparam logic [31:0] A_KSTAT = 32'hF0000110;
  localparam logic [31:0] A_SSTAT = 32'hF0000114;
  localparam logic [31:0] A_KIE = 32'hF0000120;
  typedef struct {
    logic [31:0] d;
    logic s;
    logic i;
    string n;
  } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [31:0] addr = '0;
  logic [31:0] wrData = '0;
  logic wrEn = 1'b0;
  logic [31:0] rdData;
  logic sel;
  logic [3:0] KEY = 4'hF;
  logic [9:0] SW = 10'h2A0;
  logic irq_w;
  logic rd_v = 1'b0;
  exp_t q[$];
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  keysw_io_responder #(.DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .addr(addr), .wrEn(wrEn), .wrData(wrData),
    .rdData(rdData), .sel(sel), .KEY(KEY), .SW(SW)
`ifdef KEYSW_IRQ_EN
    , .irq(irq_w)
`endif
  );
`ifndef KEYSW_IRQ_EN
  assign irq_w = 1'b0;
`endif
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic idle(input int n);
    repeat (n) cyc();
  endtask
  task automatic rd(input logic [31:0] a, input logic [31:0] d, input logic s, input logic i, input string n);
    exp_t e;
    e.d = d;
    e.s = s;
    e.i = i;
    e.n = n;
    addr = a;
    q.push_back(e);
    rd_v = 1'b1;
    @(negedge clk);
    #1 rd_v = 1'b0;
  endtask
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    addr = a;
    wrData = d;
    wrEn = 1'b1;
    cyc();
    wrEn = 1'b0;
  endtask
  always @(negedge clk) begin : mon
    exp_t e;
    logic ok;
    if (rd_v) begin
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_read: rdData=%h sel=%b", rdData, sel);
      end else begin
        e = q.pop_front();
        checks++;
        ok = rdData === e.d && sel === e.s;
`ifdef KEYSW_IRQ_EN
        ok = ok && irq_w === e.i;
`endif
        if (!ok) begin
          errors++;
          $display("FAIL %s: got rdData=%h sel=%b irq=%b, expected rdData=%h sel=%b irq=%b",
                   e.n, rdData, sel, irq_w, e.d, e.s, e.i);
        end
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    repeat (2) @(posedge clk);
    #1;
    rd(A_SW, 32'h0, 1'b1, 1'b0, "rst_rd_zero");
    @(posedge clk);
    #1 reset = 1'b0;
    idle(4);
    rd(A_SW, 32'h2A0, 1'b1, 1'b0, "init_sdata");
    rd(A_SSTAT, 32'h0, 1'b1, 1'b0, "init_sstat");
    rd(A_KSTAT, 32'h0, 1'b1, 1'b0, "init_kstat");
    rd(A_KEY, 32'h0, 1'b1, 1'b0, "init_kdata");
    cyc();
    KEY = 4'hD;
    for (int k = 1; k <= 6; k++) begin
      cyc();
      rd(A_KEY, (k == 6) ? 32'h2 : 32'h0, 1'b1, 1'b0, "key1_latency");
    end
    rd(A_KSTAT, 32'h2, 1'b1, 1'b0, "key1_flag");
    wr(A_KSTAT, 32'h2);
    rd(A_KSTAT, 32'h0, 1'b1, 1'b0, "key1_w1c");
    rd(A_KEY, 32'h2, 1'b1, 1'b0, "key1_held");
    KEY = 4'hF;
    idle(8);
    rd(A_KEY, 32'h0, 1'b1, 1'b0, "key1_release");
    rd(A_KSTAT, 32'h0, 1'b1, 1'b0, "key1_release_noflag");
    cyc();
    KEY = 4'hE;
    idle(3);
    KEY = 4'hF;
    for (int k = 0; k < 8; k++) begin
      cyc();
      rd(A_KEY, 32'h0, 1'b1, 1'b0, "glitch_kdata");
    end
    rd(A_KSTAT, 32'h0, 1'b1, 1'b0, "glitch_kstat");
    KEY = 4'hB;
    idle(8);
    KEY = 4'hF;
    idle(8);
    KEY = 4'hB;
    idle(8);
    rd(A_KSTAT, 32'h14, 1'b1, 1'b0, "overrun_kstat");
    KEY = 4'hF;
    idle(8);
    wr(A_KSTAT, 32'h10);
    rd(A_KSTAT, 32'h04, 1'b1, 1'b0, "overrun_clear_ov");
    wr(A_KSTAT, 32'h04);
    rd(A_KSTAT, 32'h0, 1'b1, 1'b0, "overrun_clear_all");
    KEY = 4'h7;
    idle(8);
    KEY = 4'hF;
    idle(8);
    rd(A_KSTAT, 32'h08, 1'b1, 1'b0, "simul_preset");
    cyc();
    KEY = 4'h7;
    idle(5);
    wr(A_KSTAT, 32'h08);
    rd(A_KSTAT, 32'h08, 1'b1, 1'b0, "simul_set_wins");
    KEY = 4'hF;
    idle(8);
    wr(A_KSTAT, 32'h08);
    rd(A_KSTAT, 32'h0, 1'b1, 1'b0, "simul_cleanup");
    rd(32'hF0000018, 32'h0, 1'b0, 1'b0, "unmapped_read");
    wr(A_SW, 32'h3FF);
    rd(A_SW, 32'h2A0, 1'b1, 1'b0, "sdata_write_ignored");
    wr(A_KEY, 32'hF);
    rd(A_KEY, 32'h0, 1'b1, 1'b0, "kdata_write_ignored");
    SW = 10'h2A1;
    idle(8);
    rd(A_SW, 32'h2A1, 1'b1, 1'b0, "sw0_sdata");
    rd(A_SSTAT, 32'h001, 1'b1, 1'b0, "sw0_flag");
    SW = 10'h2A0;
    idle(8);
    rd(A_SSTAT, 32'h401, 1'b1, 1'b0, "sw0_overrun");
    wr(A_SSTAT, 32'h401);
    rd(A_SSTAT, 32'h0, 1'b1, 1'b0, "sstat_clear");
`ifdef KEYSW_IRQ_EN
    wr(A_KIE, 32'h10);
    rd(A_KIE, 32'h10, 1'b1, 1'b0, "kie_read");
    cyc();
    SW = 10'h280;
    for (int k = 1; k <= 7; k++) begin
      cyc();
      rd(A_SSTAT, (k >= 6) ? 32'h20 : 32'h0, 1'b1, k == 7, "irq_assert");
    end
    wr(A_SSTAT, 32'h20);
    rd(A_SSTAT, 32'h0, 1'b1, 1'b1, "irq_after_clear_edge");
    rd(A_SSTAT, 32'h0, 1'b1, 1'b0, "irq_deassert");
`else
    rd(A_KIE, 32'h0, 1'b0, 1'b0, "kie_unmapped");
`endif
    cyc();
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d expected entries left, expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
